prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 151 +++++++++++++++
 tb/tb_prog_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: writer side of the nRisc instruction memory.
// Receives a framed program image (LEN, N payload bytes, XOR checksum) over a
// valid/ready byte stream. It writes each payload byte to consecutive
// addresses starting at BASE. The core is held from the start of a load until
// the image has been verified. After a failed load the core stays held until
// a later load succeeds.

module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128,
    parameter int BASE   = 0
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    // Largest image that still fits between BASE and the end of memory.
    localparam int                MAX_LEN   = DEPTH - BASE;
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    state_e            state_q, state_d;
    logic [7:0]        count_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic accept;
    logic lenBad;

    // in_ready is decoded from state only, so accept never loops back into it.
    assign accept = in_valid && in_ready;
    assign lenBad = (in_data == 8'd0) || (int'(in_data) > MAX_LEN);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // State register; an asynchronous reset abandons any load in progress.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame parser: advances only on accepted beats, or on start when not loading.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) state_d = lenBad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && (count_q == 8'd1)) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) state_d = S_LEN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs; the core is held in every state except IDLE, including ERR.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            S_IDLE: cpu_hold = 1'b0;
            S_LEN, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: cpu_hold = 1'b1;
        endcase
    end

    // Datapath: byte counter, running XOR, and the registered memory write port.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 8'd0;
            csum_q      <= 8'd0;
            next_addr_q <= BASE_ADDR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 8'd0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                S_LEN: begin
                    if (accept && !lenBad) begin
                        count_q     <= in_data;
                        next_addr_q <= BASE_ADDR;
                        csum_q      <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= next_addr_q;
                        mem_wdata_q <= in_data;
                        next_addr_q <= next_addr_q + ADDR_W'(1);
                        csum_q      <= csum_q ^ in_data;
                        count_q     <= count_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames for prog_loader.
// A frame-level reference model predicts every output on every cycle.
// Literal write logs and status values pin the directed scenarios.

module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 128;
    localparam int BASE   = 0;

    logic              ck = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic              inValid = 1'b0;
    logic [7:0]        inData = 8'd0;
    logic              inReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memWdata;
    logic              cpuHold;
    logic              done;
    logic              err;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int doneCount = 0;
    logic [15:0] writeLog[$];

    // Reference model: 0 idle, 1 inside a frame, 2 done pulse, 3 error.
    int          mMode = 0;
    int          mPos = 0;
    int          mLen = 0;
    int          mK = 0;
    logic [7:0]  mXor = 8'd0;
    logic        mWe = 1'b0;
    logic        mWeNext;
    logic [7:0]  mAddr = 8'(BASE);
    logic [7:0]  mWdata = 8'd0;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (inReady),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .cpu_hold  (cpuHold),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 ck = ~ck;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: interprets the byte stream by frame position, not by RTL state.
    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            mMode  = 0;
            mPos   = 0;
            mLen   = 0;
            mK     = 0;
            mXor   = 8'd0;
            mWe    = 1'b0;
            mAddr  = 8'(BASE);
            mWdata = 8'd0;
        end else begin
            mWeNext = 1'b0;
            case (mMode)
                0: if (start) begin mMode = 1; mPos = 0; end
                1: if (inValid) begin
                    if (mPos == 0) begin
                        if (inData == 8'd0 || int'(inData) > DEPTH - BASE) mMode = 3;
                        else begin mLen = int'(inData); mPos = 1; mK = 0; mXor = 8'd0; end
                    end else if (mK < mLen) begin
                        mWeNext = 1'b1;
                        mAddr   = 8'(BASE + mK);
                        mWdata  = inData;
                        mXor    = mXor ^ inData;
                        mK++;
                    end else begin
                        mMode = (inData == mXor) ? 2 : 3;
                    end
                end
                2: mMode = 0;
                3: if (start) begin mMode = 1; mPos = 0; end
                default: mMode = 0;
            endcase
            mWe = mWeNext;
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge ck) begin
        checkOutput("in_ready", 32'(inReady), 32'(mMode == 1));
        checkOutput("busy", 32'(busy), 32'(mMode == 1));
        checkOutput("done", 32'(done), 32'(mMode == 2));
        checkOutput("err", 32'(err), 32'(mMode == 3));
        checkOutput("cpu_hold", 32'(cpuHold), 32'(mMode != 0));
        checkOutput("mem_we", 32'(memWe), 32'(mWe));
        checkOutput("mem_addr", 32'(memAddr), 32'(mAddr));
        checkOutput("mem_wdata", 32'(memWdata), 32'(mWdata));
        if (memWe === 1'b1) writeLog.push_back({memAddr, memWdata});
        if (done === 1'b1) doneCount++;
    end

    task automatic pulseStart();
        @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    // gapMode 0: valid held high; 1: toggling every cycle; 2: random gaps.
    task automatic applyStimulus(input logic [7:0] bytesIn[$], input int gapMode);
        int cyc = 0;
        for (int i = 0; i < bytesIn.size(); i++) begin
            bit sent = 0;
            int budget = 0;
            while (!sent) begin
                bit v;
                @(negedge ck);
                cyc++;
                case (gapMode)
                    1:       v = (cyc % 2) == 1;
                    2:       v = $urandom_range(0, 3) != 0;
                    default: v = 1'b1;
                endcase
                inValid = v;
                inData  = v ? bytesIn[i] : 8'($urandom);
                if (v && inReady === 1'b1) sent = 1;
                budget++;
                if (!sent && budget > 40) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL stream_timeout: byte %0d never accepted, in_ready=%0b", i, inReady);
                    inValid = 1'b0;
                    return;
                end
            end
        end
        @(negedge ck);
        inValid = 1'b0;
    endtask

    task automatic checkLog(input string name, input logic [15:0] exp[$]);
        checkOutput({name, "_count"}, 32'(writeLog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < writeLog.size(); i++)
            checkOutput($sformatf("%s_w%0d", name, i), 32'(writeLog[i]), 32'(exp[i]));
    endtask

    task automatic clearLog();
        writeLog.delete();
        doneCount = 0;
    endtask

    logic [7:0]  nominal[$];
    logic [15:0] expNom[$];

    initial begin
        logic [7:0] frame[$];
        logic [15:0] expW[$];

        nominal = '{8'h07, 8'h00, 8'h34, 8'h40, 8'h58, 8'h71, 8'h00, 8'h90, 8'hCD};
        expNom  = '{16'h0000, 16'h0134, 16'h0240, 16'h0358, 16'h0471, 16'h0500, 16'h0690};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);
        checkOutput("rst_mem_we", 32'(memWe), 32'd0);
        checkOutput("rst_mem_addr", 32'(memAddr), 32'(BASE));
        checkOutput("rst_cpu_hold", 32'(cpuHold), 32'd0);
        @(negedge ck);
        rst_n = 1'b1;

        $display("[TB] nominal load");
        clearLog();
        pulseStart();
        applyStimulus(nominal, 0);
        repeat (3) @(negedge ck);
        checkLog("nominal", expNom);
        checkOutput("nominal_done_count", 32'(doneCount), 32'd1);
        checkOutput("nominal_err", 32'(err), 32'd0);
        checkOutput("nominal_hold_after", 32'(cpuHold), 32'd0);

        $display("[TB] back-pressure load");
        clearLog();
        pulseStart();
        applyStimulus(nominal, 1);
        repeat (3) @(negedge ck);
        checkLog("backpressure", expNom);
        checkOutput("backpressure_done_count", 32'(doneCount), 32'd1);

        $display("[TB] length errors");
        clearLog();
        pulseStart();
        frame = '{8'h00};
        applyStimulus(frame, 0);
        repeat (2) @(negedge ck);
        checkOutput("len0_err", 32'(err), 32'd1);
        checkOutput("len0_hold", 32'(cpuHold), 32'd1);
        checkOutput("len0_writes", 32'(writeLog.size()), 32'd0);
        pulseStart();
        frame = '{8'h81};
        applyStimulus(frame, 0);
        repeat (2) @(negedge ck);
        checkOutput("len129_err", 32'(err), 32'd1);
        checkOutput("len129_writes", 32'(writeLog.size()), 32'd0);
        pulseStart();
        frame = '{8'h01, 8'h5A, 8'h5A};
        applyStimulus(frame, 0);
        repeat (3) @(negedge ck);
        expW = '{16'h005A};
        checkLog("rearm", expW);
        checkOutput("rearm_err", 32'(err), 32'd0);
        checkOutput("rearm_done_count", 32'(doneCount), 32'd1);

        $display("[TB] bad checksum");
        clearLog();
        pulseStart();
        frame = '{8'h02, 8'hAA, 8'h55, 8'hFE};
        applyStimulus(frame, 0);
        repeat (3) @(negedge ck);
        expW = '{16'h00AA, 16'h0155};
        checkLog("badcsum", expW);
        checkOutput("badcsum_err", 32'(err), 32'd1);
        checkOutput("badcsum_done_count", 32'(doneCount), 32'd0);
        checkOutput("badcsum_hold", 32'(cpuHold), 32'd1);

        $display("[TB] reset mid-load");
        pulseStart();
        frame = '{8'h07, 8'h00, 8'h34, 8'h40};
        applyStimulus(frame, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(inReady), 32'd0);
        checkOutput("midrst_mem_we", 32'(memWe), 32'd0);
        checkOutput("midrst_mem_addr", 32'(memAddr), 32'(BASE));
        checkOutput("midrst_mem_wdata", 32'(memWdata), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_hold", 32'(cpuHold), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        @(negedge ck);
        rst_n = 1'b1;
        clearLog();
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            inValid = 1'b1;
            inData  = 8'($urandom);
            checkOutput("nostart_in_ready", 32'(inReady), 32'd0);
        end
        @(negedge ck);
        inValid = 1'b0;
        checkOutput("nostart_writes", 32'(writeLog.size()), 32'd0);

        $display("[TB] start while busy");
        clearLog();
        pulseStart();
        fork
            applyStimulus(nominal, 0);
            begin
                repeat (4) @(negedge ck);
                start = 1'b1;
                @(negedge ck);
                start = 1'b0;
            end
        join
        repeat (3) @(negedge ck);
        checkLog("busystart", expNom);
        checkOutput("busystart_done_count", 32'(doneCount), 32'd1);

        $display("[TB] random frames");
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(0, 9);
            int n = $urandom_range(1, 24);
            logic [7:0] x = 8'd0;
            frame.delete();
            pulseStart();
            if (kind == 0) begin
                frame.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(129, 255)));
            end else begin
                frame.push_back(8'(n));
                for (int j = 0; j < n; j++) begin
                    logic [7:0] b = 8'($urandom);
                    frame.push_back(b);
                    x = x ^ b;
                end
                frame.push_back((kind == 1) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
            end
            applyStimulus(frame, 2);
            repeat (3) @(negedge ck);
        end
        frame = '{8'h80};
        for (int j = 0; j < 128; j++) frame.push_back(8'(j));
        frame.push_back(8'h00);
        clearLog();
        pulseStart();
        applyStimulus(frame, 0);
        repeat (3) @(negedge ck);
        checkOutput("fulldepth_writes", 32'(writeLog.size()), 32'd128);
        checkOutput("fulldepth_done_count", 32'(doneCount), 32'd1);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
